// File: rtl/npc_alu_pkg.sv
// Shared definitions for the NPC execute-stage integer ALU blocks.
// Op encodings and width helpers used by the pipelined add/subtract unit.
package npc_alu_pkg;

  localparam logic [1:0] ADDER_OP_ADD  = 2'b00;
  localparam logic [1:0] ADDER_OP_SUB  = 2'b01;
  localparam logic [1:0] ADDER_OP_ADDW = 2'b10;
  localparam logic [1:0] ADDER_OP_SUBW = 2'b11;

  localparam int WORD_BITS = 32;

  function automatic int chunk_bits(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One register slice of the pipelined adder: adds chunk IDX of the operands
// with the incoming carry and forwards the partial sum plus remaining operands.
module addsub_slice #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 32,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [1:0]       out_op
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [1:0]       op_q, op_d;
  logic [CHUNK:0]   part;
  logic             advance;

  assign part = {1'b0, in_a[IDX*CHUNK +: CHUNK]} + {1'b0, in_b[IDX*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, in_carry};
  assign advance  = !valid_q || out_ready;
  assign in_ready = advance;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    op_d    = op_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (advance) begin
      valid_d = in_valid;
      // Payload only loads on a real op so stalled/idle outputs stay put.
      if (in_valid) begin
        a_d   = in_a;
        b_d   = in_b;
        sum_d = in_sum;
        sum_d[IDX*CHUNK +: CHUNK] = part[CHUNK-1:0];
        carry_d = part[CHUNK];
        op_d    = in_op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 2'b00;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      op_q    <= op_d;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_sum   = sum_q;
  assign out_carry = carry_q;
  assign out_op    = op_q;

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined integer add/subtract with RV64 word ops, flags and valid/ready
// handshakes; the carry chain is cut into STAGES registered slices.
module pipe_addsub
  import npc_alu_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int STAGES  = 2,
  parameter int WORD_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK   = chunk_bits(WIDTH, STAGES);
  localparam bit WORD_OK = (WORD_EN != 0) && (WIDTH == 64);

  logic             valid_s [0:STAGES];
  logic             ready_s [0:STAGES];
  logic [WIDTH-1:0] a_s     [0:STAGES];
  logic [WIDTH-1:0] b_s     [0:STAGES];
  logic [WIDTH-1:0] sum_s   [0:STAGES];
  logic             carry_s [0:STAGES];
  logic [1:0]       op_s    [0:STAGES];

  logic [WIDTH-1:0] a_prep, b_prep;

  generate
    if (WORD_OK) begin : g_prep_word
      always_comb begin
        a_prep = src1;
        b_prep = op[0] ? ~src2 : src2;
        if (op[1]) begin
          a_prep[WIDTH-1:WORD_BITS] = '0;
          b_prep[WIDTH-1:WORD_BITS] = '0;
        end
      end
    end else begin : g_prep_full
      always_comb begin
        a_prep = src1;
        b_prep = op[0] ? ~src2 : src2;
      end
    end
  endgenerate

  assign valid_s[0] = in_valid && !flush;
  assign a_s[0]     = a_prep;
  assign b_s[0]     = b_prep;
  assign sum_s[0]   = '0;
  assign carry_s[0] = op[0];
  assign op_s[0]    = op;
  assign in_ready   = !flush && ready_s[0];
  assign ready_s[STAGES] = out_ready;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
      addsub_slice #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .IDX   (gi)
      ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (valid_s[gi]),
        .in_ready  (ready_s[gi]),
        .in_a      (a_s[gi]),
        .in_b      (b_s[gi]),
        .in_sum    (sum_s[gi]),
        .in_carry  (carry_s[gi]),
        .in_op     (op_s[gi]),
        .out_valid (valid_s[gi+1]),
        .out_ready (ready_s[gi+1]),
        .out_a     (a_s[gi+1]),
        .out_b     (b_s[gi+1]),
        .out_sum   (sum_s[gi+1]),
        .out_carry (carry_s[gi+1]),
        .out_op    (op_s[gi+1])
      );
    end
  endgenerate

  logic [WIDTH-1:0] sum_f, a_f, b_f;
  logic             carry_f;
  logic [1:0]       op_f;

  assign sum_f   = sum_s[STAGES];
  assign a_f     = a_s[STAGES];
  assign b_f     = b_s[STAGES];
  assign carry_f = carry_s[STAGES];
  assign op_f    = op_s[STAGES];

  // b_f is already inverted for subtracts, so one overflow rule covers both.
  generate
    if (WORD_OK) begin : g_flag_word
      always_comb begin
        if (op_f[1]) begin
          result   = {{(WIDTH-WORD_BITS){sum_f[WORD_BITS-1]}}, sum_f[WORD_BITS-1:0]};
          cout     = sum_f[WORD_BITS];
          overflow = (a_f[WORD_BITS-1] == b_f[WORD_BITS-1])
                  && (sum_f[WORD_BITS-1] != a_f[WORD_BITS-1]);
        end else begin
          result   = sum_f;
          cout     = carry_f;
          overflow = (a_f[WIDTH-1] == b_f[WIDTH-1]) && (sum_f[WIDTH-1] != a_f[WIDTH-1]);
        end
      end
    end else begin : g_flag_full
      always_comb begin
        result   = sum_f;
        cout     = carry_f;
        overflow = (a_f[WIDTH-1] == b_f[WIDTH-1]) && (sum_f[WIDTH-1] != a_f[WIDTH-1]);
      end
    end
  endgenerate

  assign zero      = (result == '0);
  assign out_valid = valid_s[STAGES];

endmodule
